mem_access_unit: RTL and testbench

Memory-stage load/store unit that sits directly upstream of the data memory. It takes one byte-addressed load or store per request from the MEM pipeline stage and turns it into word-indexed accesses on the data memory port. It performs sub-word extraction and sign extension for loads, and read-modify-write for sub-word stores, because the data memory is word-wide with no byte enables. It also flags misaligned and out-of-range accesses, and stalls the pipeline while busy.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a word-wide data
// memory without byte enables. Loads are extracted and extended from the
// read word; sub-word stores are done as read-modify-write. Misaligned,
// out-of-range and illegal-size requests complete with an error and no
// memory traffic. Byte order is big-endian (offset 0 = bits [31:24]).
module mem_access_unit #(
    parameter int unsigned DATA_MEM_SIZE = 4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  size_r;
    logic [1:0]  off_r;
    logic        signed_r;
    logic [15:0] wdata_r;
    logic        accept;
    logic        acc_err;

    // Pick the addressed byte/halfword out of a big-endian word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Overlay the low byte/halfword of the store data onto the selected lane.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [15:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] m;
        m = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    m[31:24] = wdata[7:0];
                2'd1:    m[23:16] = wdata[7:0];
                2'd2:    m[15:8]  = wdata[7:0];
                default: m[7:0]   = wdata[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (off[1]) m[15:0]  = wdata;
            else        m[31:16] = wdata;
        end
        return m;
    endfunction

    // A held request is taken in IDLE, or on the edge leaving RESP so that
    // back-to-back requests do not lose a cycle.
    assign accept = req_valid && (state == IDLE || state == RESP);

    // Error classification of the request currently on the inputs.
    always_comb begin
        acc_err = 1'b0;
        if (req_size == 2'b11)                            acc_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])             acc_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)  acc_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= DATA_MEM_SIZE)     acc_err = 1'b1;
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (acc_err)                state_nxt = RESP;
                    else if (!req_write)        state_nxt = RD;
                    else if (req_size == 2'b10) state_nxt = WR;
                    else                        state_nxt = RMW_RD;
                end
            end
            RD:      state_nxt = RESP;
            RMW_RD:  state_nxt = WR;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and handshakes decoded purely from the registered state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE:        req_ready  = 1'b1;
            RD, RMW_RD:  mem_read   = 1'b1;
            WR:          mem_write  = 1'b1;
            RESP:        resp_valid = 1'b1;
            default:     req_ready  = 1'b0;
        endcase
    end

    assign stall = ~req_ready;

    // Request capture, load result, RMW merge and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address <= '0;
            mem_data_in <= '0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
        end else begin
            if (accept) begin
                mem_address <= {2'b00, req_addr[31:2]};
                mem_data_in <= req_wdata;
                wdata_r     <= req_wdata[15:0];
                size_r      <= req_size;
                off_r       <= req_addr[1:0];
                signed_r    <= req_signed;
                if (acc_err) begin
                    resp_rdata <= '0;
                    resp_error <= 1'b1;
                end
            end
            case (state)
                RD: begin
                    resp_rdata <= extract_load(mem_data_out, size_r, off_r, signed_r);
                    resp_error <= 1'b0;
                end
                RMW_RD: mem_data_in <= merge_store(mem_data_out, wdata_r, size_r, off_r);
                WR: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        stall;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic        mem_init = 1'b1;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int passed = 0;

    // Per-transaction observations filled by run_txn.
    int          lat, rd_cnt, wr_cnt, both_cnt, stall_lo;
    logic [31:0] w_addr, w_data, rdata;
    logic        err;

    mem_access_unit #(.DATA_MEM_SIZE(4000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .stall(stall), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_read(mem_read), .mem_write(mem_write),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem_read ? mem[mem_address[11:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 4096; k++) mem[k] <= 32'h0;
            mem[0] <= 32'h01020304;
            mem[5] <= 32'h80FF7F01;
            mem[6] <= 32'h11223344;
        end else if (mem_write) begin
            mem[mem_address[11:0]] <= mem_data_in;
        end
    end

    task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        lat = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0; stall_lo = 0;
        w_addr = '0; w_data = '0; rdata = 'x; err = 1'bx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_read) rd_cnt++;
            if (mem_write) begin wr_cnt++; w_addr = mem_address; w_data = mem_data_in; end
            if (mem_read && mem_write) both_cnt++;
            if (!stall) stall_lo++;
            if (resp_valid) begin rdata = resp_rdata; err = resp_error; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_init = 1'b0;
        checks++; if ({req_ready, stall, resp_valid, resp_error} !== 4'b1000) $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, stall, resp_valid, resp_error}); else passed++;
        checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); else passed++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", resp_rdata); else passed++;
        checks++; if ({mem_address, mem_data_in} !== 64'h0) $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_address, mem_data_in); else passed++;
    endtask

    task automatic test_loads();
        logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [4] = '{32'h15, 32'h15, 32'h14, 32'h16};
        logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, sz[i], sg[i], ad[i], 32'h0);
            checks++; if (rdata !== ex[i]) $display("FAIL load%0d_rdata: got %h expected %h", i, rdata, ex[i]); else passed++;
            checks++; if (lat !== 2) $display("FAIL load%0d_latency: got %0d expected 2", i, lat); else passed++;
            checks++; if ({rd_cnt, wr_cnt, 31'(err)} !== {32'd1, 32'd0, 31'd0}) $display("FAIL load%0d_traffic: rd %0d wr %0d err %b expected rd 1 wr 0 err 0", i, rd_cnt, wr_cnt, err); else passed++;
        end
    endtask

    task automatic test_byte_store();
        run_txn(1'b1, 2'b00, 1'b0, 32'h16, 32'h000000AB);
        checks++; if (lat !== 3) $display("FAIL sb_latency: got %0d expected 3", lat); else passed++;
        checks++; if (rd_cnt !== 1 || wr_cnt !== 1 || both_cnt !== 0) $display("FAIL sb_strobes: rd %0d wr %0d both %0d expected 1 1 0", rd_cnt, wr_cnt, both_cnt); else passed++;
        checks++; if (w_addr !== 32'd5) $display("FAIL sb_addr: got %h expected 5", w_addr); else passed++;
        checks++; if (w_data !== 32'h80FFAB01) $display("FAIL sb_data: got %h expected 80ffab01", w_data); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL sb_error: got %b expected 0", err); else passed++;
        run_txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        checks++; if (rdata !== 32'h80FFAB01) $display("FAIL sb_readback: got %h expected 80ffab01", rdata); else passed++;
    endtask

    task automatic test_word_store();
        run_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        checks++; if (lat !== 2) $display("FAIL sw_latency: got %0d expected 2", lat); else passed++;
        checks++; if (rd_cnt !== 0 || wr_cnt !== 1) $display("FAIL sw_strobes: rd %0d wr %0d expected 0 1", rd_cnt, wr_cnt); else passed++;
        checks++; if (w_addr !== 32'd8 || w_data !== 32'hDEADBEEF) $display("FAIL sw_bus: got %h/%h expected 8/deadbeef", w_addr, w_data); else passed++;
        checks++; if (err !== 1'b0 || rdata !== 32'h0) $display("FAIL sw_resp: err %b rdata %h expected 0/0", err, rdata); else passed++;
    endtask

    task automatic test_errors();
        logic        wr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        logic [31:0] ad [4] = '{32'h13, 32'h11, 32'd16000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_txn(wr[i], sz[i], 1'b1, ad[i], 32'h12345678);
            checks++; if (err !== 1'b1 || rdata !== 32'h0) $display("FAIL err%0d_resp: err %b rdata %h expected 1/0", i, err, rdata); else passed++;
            checks++; if (lat !== 1) $display("FAIL err%0d_latency: got %0d expected 1", i, lat); else passed++;
            checks++; if (rd_cnt !== 0 || wr_cnt !== 0) $display("FAIL err%0d_traffic: rd %0d wr %0d expected 0 0", i, rd_cnt, wr_cnt); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        run_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL pre_reset_load: got %h expected deadbeef", rdata); else passed++;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h18; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_read !== 1'b1) $display("FAIL rst_mid_in_rmw: mem_read %b expected 1", mem_read); else passed++;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({req_ready, stall, resp_valid, resp_error, mem_read, mem_write} !== 6'b100000) $display("FAIL rst_mid_ctrl: got %b expected 100000", {req_ready, stall, resp_valid, resp_error, mem_read, mem_write}); else passed++;
        checks++; if (resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_in !== 32'h0) $display("FAIL rst_mid_data: got %h/%h/%h expected 0/0/0", resp_rdata, mem_address, mem_data_in); else passed++;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_write || resp_valid) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL rst_mid_quiet: got %0d write/resp cycles expected 0", bad); else passed++;
        checks++; if (mem[6] !== 32'h11223344) $display("FAIL rst_mid_word: got %h expected 11223344", mem[6]); else passed++;
    endtask

    task automatic test_back_to_back();
        int          resp1, resp2, wcyc, slo;
        logic [31:0] r1, wa;
        resp1 = -1; resp2 = -1; wcyc = -1; slo = 0; r1 = 'x; wa = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!stall) slo++;
            if (mem_write) begin wcyc = i; wa = mem_address; req_valid = 1'b0; end
            if (resp_valid && resp1 < 0) begin resp1 = i; r1 = resp_rdata; end
            else if (resp_valid) begin resp2 = i; break; end
            if (i == 0) begin req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'hCAFEF00D; end
        end
        checks++; if (resp1 !== 1 || r1 !== 32'h01020304) $display("FAIL b2b_first: cycle %0d data %h expected 1/01020304", resp1, r1); else passed++;
        checks++; if (wcyc !== 2 || wa !== 32'd1) $display("FAIL b2b_accept: write cycle %0d addr %h expected 2/1", wcyc, wa); else passed++;
        checks++; if (resp2 !== 3) $display("FAIL b2b_second_resp: got cycle %0d expected 3", resp2); else passed++;
        checks++; if (slo !== 0) $display("FAIL b2b_stall: %0d busy cycles with stall low, expected 0", slo); else passed++;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_idle: stall %b ready %b expected 0/1", stall, req_ready); else passed++;
        checks++; if (mem[1] !== 32'hCAFEF00D) $display("FAIL b2b_word: got %h expected cafef00d", mem[1]); else passed++;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_byte_store();
        test_word_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
